// File: rtl/bs_vector_sequencer_if.sv
// Handshake/bus bundle between the vector sequencer, its BRAM and the barrel shifter.
// master = sequencer side, slave = the surrounding lab top / bench side.
interface bs_vector_sequencer_if #(
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 3,
    parameter int ADDR_W  = 3
);
    logic                      start_stop;
    logic                      left_right;
    logic                      rotate;
    logic                      one_shot;
    logic [DATA_W+SHIFT_W-1:0] douta;
    logic                      ena;
    logic [ADDR_W-1:0]         addra;
    logic [DATA_W-1:0]         in1;
    logic [SHIFT_W-1:0]        shift;
    logic                      LR;
    logic                      ROT;
    logic                      out_valid;
    logic                      busy;
    logic                      done;

    modport master (
        input  start_stop, left_right, rotate, one_shot, douta,
        output ena, addra, in1, shift, LR, ROT, out_valid, busy, done
    );

    modport slave (
        output start_stop, left_right, rotate, one_shot, douta,
        input  ena, addra, in1, shift, LR, ROT, out_valid, busy, done
    );
endinterface

// File: rtl/bs_vector_sequencer.sv
// Sweeps packed {data, shift} vectors out of a single-port BRAM into the barrel-shifter
// operand registers. Define BS_SEQ_STEP_EN to add a `step` input that gates each issue.
module bs_vector_sequencer #(
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 3,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 8,
    parameter int RD_LAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef BS_SEQ_STEP_EN
    input  logic            step,
`endif
    bs_vector_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam bit                 DATA_POW2 = (DATA_W & (DATA_W - 1)) == 0;
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                os_q, os_nxt;
    logic                fin_q, fin_nxt;
    logic                step_ok;
    logic                issue;

    logic [RD_LAT-1:0]   vld_pipe, lr_pipe, rot_pipe;
    logic [RD_LAT-1:0]   vld_nxt, lr_nxt, rot_nxt;
    logic                pipe_empty_nxt;
    logic                tail;

    logic [DATA_W-1:0]   in1_r;
    logic [SHIFT_W-1:0]  shift_r;
    logic                lr_r, rot_r, ov_r;
    logic [SHIFT_W-1:0]  shf_raw, shf_cap;

`ifdef BS_SEQ_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    // Kept outside the FSM process so the drain test below has no loop through it.
    assign issue = (state == S_RUN) && step_ok;

    // Mode bits ride alongside the read so they meet their own vector at capture.
    if (RD_LAT == 1) begin : g_lat1
        assign vld_nxt = issue;
        assign lr_nxt  = bus.left_right;
        assign rot_nxt = bus.rotate;
    end else begin : g_latn
        assign vld_nxt = {vld_pipe[RD_LAT-2:0], issue};
        assign lr_nxt  = {lr_pipe[RD_LAT-2:0],  bus.left_right};
        assign rot_nxt = {rot_pipe[RD_LAT-2:0], bus.rotate};
    end

    assign pipe_empty_nxt = (vld_nxt == '0);
    assign tail           = vld_pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            lr_pipe  <= '0;
            rot_pipe <= '0;
        end else begin
            vld_pipe <= vld_nxt;
            lr_pipe  <= lr_nxt;
            rot_pipe <= rot_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            os_q   <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            os_q   <= os_nxt;
            fin_q  <= fin_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        os_nxt    = os_q;
        fin_nxt   = fin_q;
        unique case (state)
            S_IDLE: begin
                addr_nxt = '0;
                if (bus.start_stop) begin
                    state_nxt = S_RUN;
                    os_nxt    = bus.one_shot;
                    fin_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        // One-shot parks on the last address until the drain finishes.
                        if (os_q) fin_nxt  = 1'b1;
                        else      addr_nxt = '0;
                    end else begin
                        addr_nxt = addr_q + 1'b1;
                    end
                end
                if (!bus.start_stop || (issue && os_q && addr_q == LAST_ADDR))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pipe_empty_nxt) begin
                    state_nxt = fin_q ? S_DONE : S_IDLE;
                    addr_nxt  = '0;
                end
            end
            S_DONE: begin
                addr_nxt = '0;
                if (!bus.start_stop) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign shf_raw = bus.douta[SHIFT_W-1:0];

    // A non-power-of-two word cannot use the top shift codes; pin them to the widest legal shift.
    always_comb begin
        shf_cap = shf_raw;
        if (!DATA_POW2 && (32'(shf_raw) > 32'(DATA_W - 1)))
            shf_cap = SHIFT_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_r   <= '0;
            shift_r <= '0;
            lr_r    <= 1'b0;
            rot_r   <= 1'b0;
            ov_r    <= 1'b0;
        end else begin
            ov_r <= tail;
            if (tail) begin
                in1_r   <= bus.douta[DATA_W+SHIFT_W-1:SHIFT_W];
                shift_r <= shf_cap;
                lr_r    <= lr_pipe[RD_LAT-1];
                rot_r   <= rot_pipe[RD_LAT-1];
            end
        end
    end

    assign bus.ena       = issue;
    assign bus.addra     = addr_q;
    assign bus.in1       = in1_r;
    assign bus.shift     = shift_r;
    assign bus.LR        = lr_r;
    assign bus.ROT       = rot_r;
    assign bus.out_valid = ov_r;
    assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
    assign bus.done      = (state == S_DONE);

endmodule

// File: tb/tb_bs_vector_sequencer.sv
// Bench for bs_vector_sequencer: hand-derived stop table, then randomized and directed
// sequences checked against a queue-based transaction model with a behavioural BRAM.
module tb_bs_vector_sequencer;
    localparam int DATA_W  = 6;
    localparam int SHIFT_W = 3;
    localparam int ADDR_W  = 3;
    localparam int DEPTH   = 6;
    localparam int RD_LAT  = 2;
    localparam int W       = DATA_W + SHIFT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic step = 1'b1;

    always #5 clk = ~clk;

    bs_vector_sequencer_if #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .ADDR_W(ADDR_W)) bus();

    bs_vector_sequencer #(
        .DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef BS_SEQ_STEP_EN
        .step(step),
`endif
        .bus(bus)
    );

    // Behavioural BRAM with RD_LAT cycles of read latency.
    logic [W-1:0] mem [2**ADDR_W];
    logic [W-1:0] rd0, rd1;
    always @(posedge clk) begin
        if (bus.ena) rd0 <= mem[bus.addra];
        rd1 <= rd0;
    end
    assign bus.douta = (RD_LAT == 1) ? rd0 : rd1;

    int total = 0;
    int bad   = 0;

    typedef struct { int cap; int addr; bit lr; bit rot; } rd_t;
    rd_t pend[$];
    int  m_mode, m_addr, cyc, m_in1, m_sh;
    bit  m_os, m_fin, m_ov, m_lr, m_rot;

    typedef struct {
        logic ss; logic ena; int addra; logic ov; logic busy; logic done; int src;
    } vec_t;

    function automatic int exp_in1(input int a);
        return (a * 17) % (1 << DATA_W);
    endfunction

    function automatic int exp_sh(input int a);
        int s;
        s = (a + 2) % (1 << SHIFT_W);
        if (((DATA_W & (DATA_W - 1)) != 0) && s > DATA_W - 1) s = DATA_W - 1;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "ena"},   32'(bus.ena),       32'(0));
        chk({p, "addra"}, 32'(bus.addra),     32'(0));
        chk({p, "in1"},   32'(bus.in1),       32'(0));
        chk({p, "shift"}, 32'(bus.shift),     32'(0));
        chk({p, "LR"},    32'(bus.LR),        32'(0));
        chk({p, "ROT"},   32'(bus.ROT),       32'(0));
        chk({p, "ov"},    32'(bus.out_valid), 32'(0));
        chk({p, "busy"},  32'(bus.busy),      32'(0));
        chk({p, "done"},  32'(bus.done),      32'(0));
    endtask

    task automatic model_reset();
        m_mode = 0; m_addr = 0; m_os = 0; m_fin = 0;
        m_ov = 0; m_in1 = 0; m_sh = 0; m_lr = 0; m_rot = 0;
        pend.delete();
    endtask

    // Called just after a negedge with this cycle's inputs applied; checks, advances one edge.
    task automatic model_cycle();
        bit e, last;
        int nmode;
        rd_t r;
        #1;
        e = (m_mode == 1) && step;
        chk("ena",       32'(bus.ena),       32'(e));
        chk("addra",     32'(bus.addra),     32'(m_addr));
        chk("busy",      32'(bus.busy),      32'(m_mode == 1 || m_mode == 2));
        chk("done",      32'(bus.done),      32'(m_mode == 3));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("in1",       32'(bus.in1),       32'(m_in1));
        chk("shift",     32'(bus.shift),     32'(m_sh));
        chk("LR",        32'(bus.LR),        32'(m_lr));
        chk("ROT",       32'(bus.ROT),       32'(m_rot));
        if (e) pend.push_back('{cyc + RD_LAT + 1, m_addr, bus.left_right, bus.rotate});
        m_ov = 0;
        if (pend.size() > 0 && pend[0].cap == cyc + 1) begin
            r = pend.pop_front();
            m_ov = 1; m_in1 = exp_in1(r.addr); m_sh = exp_sh(r.addr);
            m_lr = r.lr; m_rot = r.rot;
        end
        last  = (m_addr == DEPTH - 1);
        nmode = m_mode;
        case (m_mode)
            0: begin
                m_addr = 0;
                if (bus.start_stop) begin nmode = 1; m_os = bus.one_shot; m_fin = 0; end
            end
            1: begin
                if (e) begin
                    if (!last)     m_addr++;
                    else if (m_os) m_fin = 1;
                    else           m_addr = 0;
                end
                if (!bus.start_stop || (e && last && m_os)) nmode = 2;
            end
            2: if (pend.size() == 0) begin nmode = m_fin ? 3 : 0; m_addr = 0; end
            default: if (!bus.start_stop) nmode = 0;
        endcase
        m_mode = nmode;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[9];
        int   nov;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = {DATA_W'(i * 17), SHIFT_W'(i + 2)};
        // Continuous run, start_stop dropped so the edge ending the addr-3 cycle samples 0.
        tbl[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 0};
        tbl[5] = '{1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1};
        tbl[6] = '{1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2};
        tbl[7] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 3};
        tbl[8] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};

        cyc = 0;
        bus.start_stop = 1'b0; bus.left_right = 1'b0; bus.rotate = 1'b0; bus.one_shot = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk_zero("rst_");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus.start_stop = tbl[i].ss;
            #1;
            chk("t_ena",  32'(bus.ena),       32'(tbl[i].ena));
            chk("t_addr", 32'(bus.addra),     32'(tbl[i].addra));
            chk("t_ov",   32'(bus.out_valid), 32'(tbl[i].ov));
            chk("t_busy", 32'(bus.busy),      32'(tbl[i].busy));
            chk("t_done", 32'(bus.done),      32'(tbl[i].done));
            if (tbl[i].ov) begin
                chk("t_in1",   32'(bus.in1),   32'(exp_in1(tbl[i].src)));
                chk("t_shift", 32'(bus.shift), 32'(exp_sh(tbl[i].src)));
            end
            @(posedge clk);
            @(negedge clk);
        end

        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized run/stop/one-shot traffic.
        bus.start_stop = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) bus.start_stop = ~bus.start_stop;
            bus.one_shot   = 1'($urandom_range(1));
            bus.left_right = 1'($urandom_range(1));
            bus.rotate     = 1'($urandom_range(1));
`ifdef BS_SEQ_STEP_EN
            step = ($urandom_range(2) != 0);
`endif
            model_cycle();
        end

        // One-shot sweep: exactly DEPTH captures, then done held while start_stop stays high.
        step = 1'b1;
        bus.start_stop = 1'b0;
        repeat (8) model_cycle();
        bus.one_shot = 1'b1;
        bus.start_stop = 1'b1;
        nov = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) nov++;
            model_cycle();
        end
        chk("oneshot_pulses", 32'(nov), 32'(DEPTH));
        chk("oneshot_done", 32'(bus.done), 32'(1));
        bus.start_stop = 1'b0;
        repeat (3) model_cycle();

        // Direction toggled every cycle must stay attached to its vector.
        bus.one_shot = 1'b0;
        bus.start_stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.left_right = ~bus.left_right;
            bus.rotate     = 1'($urandom_range(1));
            model_cycle();
        end

        // Asynchronous reset between edges mid-sweep, then restart from address 0.
        #2 rst = 1'b1;
        #1 chk_zero("arst_");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) model_cycle();

`ifdef BS_SEQ_STEP_EN
        for (int i = 0; i < 30; i++) begin
            step = (i % 3 == 0);
            model_cycle();
        end
        step = 1'b1;
`endif
        bus.start_stop = 1'b0;
        repeat (6) model_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bs_vector_sequencer.md
# bs_vector_sequencer

Parametrised sequencer that reads packed test vectors (data word plus shift amount) from a single-port BRAM and presents them, with per-vector direction and rotate mode, to the barrel shifter datapath. It sits between the vector BRAM and the barrel shifter in the shifter lab top level. It adds read-latency tracking, an output valid strobe, one-shot and continuous sweep modes, and clean stop/drain behaviour.

## Interface
Parameters:
- DATA_W, 8: data word width fed to the shifter.
- SHIFT_W, 3: shift-amount field width.
- ADDR_W, 3: BRAM address width.
- DEPTH, 8: number of vectors swept. Legal range 1..2^ADDR_W.
- RD_LAT, 1: BRAM read latency in cycles. Legal range 1..2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_stop  in  1  level. 1 = run, 0 = stop.
- left_right  in  1  direction request. 1 = left.
- rotate  in  1  1 = rotate, 0 = logical shift.
- one_shot  in  1  1 = sweep DEPTH vectors once, then stop. Sampled on IDLE→RUN.
- douta  in  DATA_W+SHIFT_W  BRAM read data. Data occupies [DATA_W+SHIFT_W-1:SHIFT_W]; shift occupies [SHIFT_W-1:0].
- ena  out  1  BRAM read enable.
- addra  out  ADDR_W  BRAM address.
- in1  out  DATA_W  registered data to the shifter.
- shift  out  SHIFT_W  registered shift amount.
- LR  out  1  registered direction.
- ROT  out  1  registered rotate mode.
- out_valid  out  1  one-cycle strobe when in1, shift, LR and ROT update.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.

## Operation
- States:
  - IDLE: ena=0, addra=0.
  - RUN: issue reads.
  - DRAIN: no issue; wait for in-flight reads.
  - DONE: one-shot sweep complete.
- IDLE→RUN when start_stop=1. one_shot is latched on this transition.
- RUN:
  - ena=1 every cycle; addra advances by 1 per cycle.
  - addra=DEPTH-1 with continuous mode: addra wraps to 0 on the next cycle.
  - addra=DEPTH-1 with one-shot mode: the read is issued, then the FSM moves to DRAIN.
  - start_stop=0 in RUN: ena drops the next cycle, FSM moves to DRAIN. Pending reads still complete and produce out_valid.
- DRAIN→DONE (one-shot sweep finished) or →IDLE (stopped) once the read pipeline is empty. addra returns to 0 on that transition.
- DONE→IDLE when start_stop=0. Holding start_stop=1 keeps done asserted and issues no further reads.
- Read tracking:
  - An RD_LAT-deep valid shift register follows ena.
  - left_right and rotate are sampled at issue time and carried alongside, so mode bits stay aligned with their vector.
- Capture: when the valid-pipeline tail is set, in1 and shift load from douta, LR and ROT load from the carried bits, and out_valid=1. Otherwise these outputs hold and out_valid=0.
- If DATA_W is not a power of two, a shift field greater than DATA_W-1 is clamped to DATA_W-1.
- Reset (async, any state, including mid-sweep):
  - state=IDLE, valid pipeline cleared.
  - ena=0, addra=0, in1=0, shift=0, LR=0, ROT=0.
  - out_valid=0, busy=0, done=0.

## Timing
- Read for address A is issued in cycle t (ena=1, addra=A). douta is valid at t+RD_LAT. The outputs update with out_valid=1 at edge t+RD_LAT+1.
- Continuous RUN gives back-to-back out_valid after the initial RD_LAT+1-cycle latency.
- start_stop=0 sampled at edge e: no new issue from e onward. Exactly the reads already issued (at most RD_LAT) still emit out_valid.
- DRAIN lasts RD_LAT cycles, then the FSM moves to IDLE or DONE.
- busy falls and done rises on the same edge.

## Configuration
- BS_SEQ_STEP_EN defined:
  - Adds input port step (1 bit).
  - In RUN, one read is issued per cycle in which step=1; ena=1 only in those cycles. addra advances only after a stepped issue.
  - Stop and one-shot completion apply as normal.
- BS_SEQ_STEP_EN undefined: no step port; RUN free-runs at one read per cycle.

## Test plan
- Continuous sweep: DEPTH=8, RD_LAT=1, BRAM word i = {8'(i*17), 3'(i)}, start_stop=1 held → addra cycles 0..7,0.., first out_valid 2 cycles after ena rises, in1/shift match word i, wrap with no gap.
- One-shot: one_shot=1, DEPTH=5 → exactly 5 out_valid pulses, addra sequence 0..4, done=1 two cycles after last issue, no reads while start_stop stays 1.
- Stop mid-sweep with RD_LAT=2: start_stop dropped after address 3 is issued → out_valid for addresses 0..3 only, ena=0 the next cycle, busy falls 2 cycles later, addra=0.
- Mode alignment: toggle left_right every cycle during RUN → LR at each out_valid equals the value sampled when that vector's address was issued.
- Async reset asserted mid-sweep between clock edges → all outputs 0 immediately. After release with start_stop=1, the sweep restarts at addra=0.
- BS_SEQ_STEP_EN: step pulsed on every third cycle → one issue per pulse, addra increments only on pulses, out_valid RD_LAT+1 cycles after each pulse.
